// File: rtl/eisv_mtimer_pkg.sv
// eisv_mtimer_pkg: register offsets, CTRL field positions, reset constants
// and the byte-lane merge helper shared by the machine-timer files.
package eisv_mtimer_pkg;

  // Word offsets (dmem_addr[4:2]) inside the 32-byte window
  localparam logic [2:0] MTIME_LO_OFS    = 3'd0;
  localparam logic [2:0] MTIME_HI_OFS    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO_OFS = 3'd2;
  localparam logic [2:0] MTIMECMP_HI_OFS = 3'd3;
  localparam logic [2:0] CTRL_OFS        = 3'd4;

  // CTRL field positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PRESC_LSB = 8;

  // Reset constants
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [31:0] CTRL_RST     = 32'h0000_0001;

  // Replace only the byte lanes whose enable bit is set
  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/eisv_mtimer_if.sv
// eisv_mtimer_if: data-memory port seen by the machine timer.
// master = core side, slave = timer side.
interface eisv_mtimer_if;
  logic [31:0] dmem_addr_i;
  logic        dmem_ren_i;
  logic        dmem_wen_i;
  logic [31:0] dmem_wdata_i;
  logic [3:0]  dmem_byte_enable_i;
  logic [31:0] dmem_rdata_o;
  logic        sel_o;

  modport master (
    output dmem_addr_i, dmem_ren_i, dmem_wen_i, dmem_wdata_i, dmem_byte_enable_i,
    input  dmem_rdata_o, sel_o
  );

  modport slave (
    input  dmem_addr_i, dmem_ren_i, dmem_wen_i, dmem_wdata_i, dmem_byte_enable_i,
    output dmem_rdata_o, sel_o
  );
endinterface

// File: rtl/eisv_mtimer_prescaler.sv
// eisv_mtimer_prescaler: divides the core clock by PRESC+1 while enabled.
// tick is high for the one cycle in which the counter equals PRESC.
module eisv_mtimer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = en && (cnt == presc);

  // Counter: clear on request, wrap at PRESC, hold while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/eisv_mtimer.sv
// eisv_mtimer: memory-mapped RISC-V machine timer (mtime/mtimecmp) on the
// core data-memory port. Registered read data, byte-lane writes, level irq.
// Optional build macro: EISV_MTIMER_SNAPSHOT_EN (tear-free LO-then-HI mtime
// reads through a shadow of mtime[63:32]).
module eisv_mtimer
  import eisv_mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          PRESC_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  eisv_mtimer_if.slave     bus,
  output logic             timer_irq_o
);

  logic               hit;
  logic [2:0]         ofs;
  logic               rd_hit;
  logic               wr_hit;
  logic               wr_mtime_lo;
  logic               wr_mtime_hi;
  logic               wr_cmp_lo;
  logic               wr_cmp_hi;
  logic               wr_ctrl;

  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic               en;
  logic [PRESC_W-1:0] presc;

  logic [63:0]        mtime_next;
  logic [63:0]        mtimecmp_next;
  logic               en_next;
  logic [PRESC_W-1:0] presc_next;
  logic [31:0]        ctrl_val;
  logic [31:0]        rd_val;
  logic               tick;

  logic [31:0]        rdata;
  logic               sel;
  logic               irq;

`ifdef EISV_MTIMER_SNAPSHOT_EN
  logic [31:0]        shadow;
`endif

  assign hit         = (bus.dmem_addr_i[31:5] == BASE_ADDR[31:5]);
  assign ofs         = bus.dmem_addr_i[4:2];
  assign rd_hit      = hit && bus.dmem_ren_i;
  assign wr_hit      = hit && bus.dmem_wen_i;
  assign wr_mtime_lo = wr_hit && (ofs == MTIME_LO_OFS);
  assign wr_mtime_hi = wr_hit && (ofs == MTIME_HI_OFS);
  assign wr_cmp_lo   = wr_hit && (ofs == MTIMECMP_LO_OFS);
  assign wr_cmp_hi   = wr_hit && (ofs == MTIMECMP_HI_OFS);
  assign wr_ctrl     = wr_hit && (ofs == CTRL_OFS);

  // Prescaler restarts whenever software rewrites mtime or CTRL
  eisv_mtimer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (en),
    .presc (presc),
    .clr   (wr_mtime_lo || wr_mtime_hi || wr_ctrl),
    .tick  (tick)
  );

  // Next-state of mtime/mtimecmp/CTRL: a write to either mtime half wins
  // over the tick and leaves the other half untouched (no carry)
  always_comb begin
    mtime_next    = mtime;
    mtimecmp_next = mtimecmp;
    en_next       = en;
    presc_next    = presc;

    if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo)
        mtime_next[31:0]  = merge_be(mtime[31:0], bus.dmem_wdata_i, bus.dmem_byte_enable_i);
      if (wr_mtime_hi)
        mtime_next[63:32] = merge_be(mtime[63:32], bus.dmem_wdata_i, bus.dmem_byte_enable_i);
    end else if (tick) begin
      mtime_next = mtime + 64'd1;
    end

    if (wr_cmp_lo)
      mtimecmp_next[31:0]  = merge_be(mtimecmp[31:0], bus.dmem_wdata_i, bus.dmem_byte_enable_i);
    if (wr_cmp_hi)
      mtimecmp_next[63:32] = merge_be(mtimecmp[63:32], bus.dmem_wdata_i, bus.dmem_byte_enable_i);

    if (wr_ctrl) begin
      if (bus.dmem_byte_enable_i[CTRL_EN_BIT / 8])
        en_next = bus.dmem_wdata_i[CTRL_EN_BIT];
      for (int i = 0; i < PRESC_W; i++) begin
        if (bus.dmem_byte_enable_i[(CTRL_PRESC_LSB + i) / 8])
          presc_next[i] = bus.dmem_wdata_i[CTRL_PRESC_LSB + i];
      end
    end
  end

  // CTRL image and read mux, both on pre-edge register values
  always_comb begin
    ctrl_val                              = '0;
    ctrl_val[CTRL_EN_BIT]                 = en;
    ctrl_val[CTRL_PRESC_LSB +: PRESC_W]   = presc;
    rd_val = '0;
    case (ofs)
      MTIME_LO_OFS:    rd_val = mtime[31:0];
`ifdef EISV_MTIMER_SNAPSHOT_EN
      MTIME_HI_OFS:    rd_val = shadow;
`else
      MTIME_HI_OFS:    rd_val = mtime[63:32];
`endif
      MTIMECMP_LO_OFS: rd_val = mtimecmp[31:0];
      MTIMECMP_HI_OFS: rd_val = mtimecmp[63:32];
      CTRL_OFS:        rd_val = ctrl_val;
      default:         rd_val = '0;
    endcase
  end

  // Register state, registered read response and registered compare
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      en       <= CTRL_RST[CTRL_EN_BIT];
      presc    <= CTRL_RST[CTRL_PRESC_LSB +: PRESC_W];
      rdata    <= '0;
      sel      <= 1'b0;
      irq      <= 1'b0;
    end else begin
      mtime    <= mtime_next;
      mtimecmp <= mtimecmp_next;
      en       <= en_next;
      presc    <= presc_next;
      rdata    <= rd_hit ? rd_val : '0;
      sel      <= rd_hit;
      irq      <= (mtime_next >= mtimecmp_next);
    end
  end

`ifdef EISV_MTIMER_SNAPSHOT_EN
  // Shadow of mtime[63:32]: captured by a MTIME_LO read, reloaded by a MTIME_HI write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow <= '0;
    end else if (wr_mtime_hi) begin
      shadow <= mtime_next[63:32];
    end else if (rd_hit && (ofs == MTIME_LO_OFS)) begin
      shadow <= mtime[63:32];
    end
  end
`endif

  assign bus.dmem_rdata_o = rdata;
  assign bus.sel_o        = sel;
  assign timer_irq_o      = irq;

endmodule

// File: tb/tb_eisv_mtimer.sv
// tb_eisv_mtimer: directed bench for the machine timer. Expected responses
// are queued when an access is driven and compared when it returns.
// Honours EISV_MTIMER_SNAPSHOT_EN for the MTIME_HI read expectations.
module tb_eisv_mtimer;
  import eisv_mtimer_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef EISV_MTIMER_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        sel;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  eisv_mtimer_if bus ();

  eisv_mtimer #(
    .BASE_ADDR (BASE),
    .PRESC_W   (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .timer_irq_o (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at a falling edge, compare after the next rising edge
  task automatic xfer(input logic [31:0] addr, input logic ren, input logic wen,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rd, input logic exp_sel, input string tag);
    exp_t e;
    bus.dmem_addr_i        = addr;
    bus.dmem_ren_i         = ren;
    bus.dmem_wen_i         = wen;
    bus.dmem_wdata_i       = wdata;
    bus.dmem_byte_enable_i = be;
    sb.push_back('{rdata: exp_rd, sel: exp_sel, tag: tag});
    @(negedge clk);
    bus.dmem_ren_i = 1'b0;
    bus.dmem_wen_i = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_rdata"}, bus.dmem_rdata_o, e.rdata);
    check({e.tag, "_sel"}, {31'd0, bus.sel_o}, {31'd0, e.sel});
  endtask

  task automatic rd(input logic [2:0] ofs, input logic [31:0] exp, input string tag);
    xfer(BASE + {27'd0, ofs, 2'b00}, 1'b1, 1'b0, 32'd0, 4'hF, exp, 1'b1, tag);
  endtask

  task automatic wr(input logic [2:0] ofs, input logic [31:0] d, input logic [3:0] be);
    xfer(BASE + {27'd0, ofs, 2'b00}, 1'b0, 1'b1, d, be, 32'd0, 1'b0, "wr");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.dmem_addr_i        = '0;
    bus.dmem_ren_i         = 1'b0;
    bus.dmem_wen_i         = 1'b0;
    bus.dmem_wdata_i       = '0;
    bus.dmem_byte_enable_i = '0;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    check("rst_rdata", bus.dmem_rdata_o, 32'd0);
    check("rst_sel", {31'd0, bus.sel_o}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    // Reset values; mtime starts counting at the first edge
    rd(MTIME_LO_OFS, 32'd0, "rst_mtime_lo");
    rd(MTIME_HI_OFS, 32'd0, "rst_mtime_hi");
    rd(MTIMECMP_LO_OFS, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(MTIMECMP_HI_OFS, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(CTRL_OFS, 32'h0000_0001, "rst_ctrl");
    rd(3'd5, 32'd0, "rst_rsvd");
    check("rst_irq_run", {31'd0, irq}, 32'd0);

    // Prescaler = 3: mtime advances every 4th cycle
    wr(CTRL_OFS, 32'h0000_0301, 4'hF);
    rd(CTRL_OFS, 32'h0000_0301, "presc_ctrl");
    wr(MTIME_LO_OFS, 32'd0, 4'hF);
    rd(MTIME_LO_OFS, 32'd0, "presc_t0");
    idle(39);
    rd(MTIME_LO_OFS, 32'd10, "presc_t40");
    idle(3);
    rd(MTIME_LO_OFS, 32'd11, "presc_t44");
    wr(CTRL_OFS, 32'h0000_0001, 4'hF);

    // Interrupt rises when mtime reaches 20, falls when mtimecmp is raised
    wr(MTIMECMP_HI_OFS, 32'd0, 4'hF);
    wr(MTIMECMP_LO_OFS, 32'd20, 4'hF);
    wr(MTIME_LO_OFS, 32'd0, 4'hF);
    for (int j = 0; j <= 22; j++) begin
      check($sformatf("irq_t%0d", j), {31'd0, irq}, {31'd0, (j >= 20)});
      @(negedge clk);
    end
    check("irq_held", {31'd0, irq}, 32'd1);
    wr(MTIMECMP_LO_OFS, 32'hFFFF_FFFF, 4'hF);
    check("irq_clear", {31'd0, irq}, 32'd0);

    // Low-to-high carry
    wr(MTIME_HI_OFS, 32'd0, 4'hF);
    wr(MTIME_LO_OFS, 32'hFFFF_FFFE, 4'hF);
    rd(MTIME_LO_OFS, 32'hFFFF_FFFE, "carry_lo0");
    idle(1);
    rd(MTIME_LO_OFS, 32'd0, "carry_lo2");
    rd(MTIME_HI_OFS, 32'd1, "carry_hi");

    // 64-bit wrap, and irq at all-ones compare value
    wr(MTIMECMP_HI_OFS, 32'hFFFF_FFFF, 4'hF);
    wr(MTIME_HI_OFS, 32'hFFFF_FFFF, 4'hF);
    wr(MTIME_LO_OFS, 32'hFFFF_FFFF, 4'hF);
    check("wrap_irq_max", {31'd0, irq}, 32'd1);
    rd(MTIME_LO_OFS, 32'hFFFF_FFFF, "wrap_lo_max");
    check("wrap_irq_zero", {31'd0, irq}, 32'd0);
    rd(MTIME_LO_OFS, 32'd0, "wrap_lo0");
    rd(MTIME_HI_OFS, 32'd0, "wrap_hi0");

    // Partial mtime write: other bytes keep pre-edge value, no increment
    wr(MTIME_HI_OFS, 32'd0, 4'hF);
    wr(MTIME_LO_OFS, 32'h0000_00FF, 4'hF);
    wr(MTIME_LO_OFS, 32'h0000_1200, 4'b0010);
    rd(MTIME_LO_OFS, 32'h0000_12FF, "mtime_partial");

    // Byte enables and read/write collision on MTIMECMP_LO
    wr(MTIMECMP_LO_OFS, 32'h1122_3344, 4'hF);
    wr(MTIMECMP_LO_OFS, 32'hAABB_CCDD, 4'b0101);
    rd(MTIMECMP_LO_OFS, 32'h11BB_33DD, "be_merge");
    xfer(BASE + 32'h08, 1'b1, 1'b1, 32'h1234_5678, 4'hF, 32'h11BB_33DD, 1'b1, "collide_old");
    rd(MTIMECMP_LO_OFS, 32'h1234_5678, "collide_new");

    // Misses and reserved offsets
    xfer(BASE + 32'h20, 1'b1, 1'b0, 32'd0, 4'hF, 32'd0, 1'b0, "miss_rd");
    xfer(BASE + 32'h28, 1'b1, 1'b1, 32'd0, 4'hF, 32'd0, 1'b0, "miss_wr");
    xfer(32'hFFFE_FFE8, 1'b1, 1'b1, 32'd0, 4'hF, 32'd0, 1'b0, "miss_below");
    rd(MTIMECMP_LO_OFS, 32'h1234_5678, "miss_nochange");
    wr(3'd5, 32'hFFFF_FFFF, 4'hF);
    rd(3'd5, 32'd0, "rsvd_wr");

    // EN=0 freezes mtime (the edge of the CTRL write still counts)
    wr(MTIME_HI_OFS, 32'd0, 4'hF);
    wr(MTIME_LO_OFS, 32'h0000_0100, 4'hF);
    wr(CTRL_OFS, 32'd0, 4'hF);
    idle(3);
    rd(MTIME_LO_OFS, 32'h0000_0101, "freeze_lo");
    rd(CTRL_OFS, 32'd0, "freeze_ctrl");
    wr(CTRL_OFS, 32'h0000_0001, 4'hF);

    // LO-then-HI read across a carry
    wr(MTIME_HI_OFS, 32'd0, 4'hF);
    wr(MTIME_LO_OFS, 32'hFFFF_FFFF, 4'hF);
    rd(MTIME_LO_OFS, 32'hFFFF_FFFF, "snap_lo");
    idle(5);
    rd(MTIME_HI_OFS, SNAP ? 32'd0 : 32'd1, "snap_hi");
    rd(MTIME_LO_OFS, 32'd6, "snap_lo2");
    rd(MTIME_HI_OFS, 32'd1, "snap_hi2");

    // Asynchronous reset drops an outstanding read
    bus.dmem_addr_i = BASE + 32'h0C;
    bus.dmem_ren_i  = 1'b1;
    @(posedge clk);
    #1;
    check("arst_pre_rdata", bus.dmem_rdata_o, 32'hFFFF_FFFF);
    check("arst_pre_sel", {31'd0, bus.sel_o}, 32'd1);
    bus.dmem_ren_i = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_rdata", bus.dmem_rdata_o, 32'd0);
    check("arst_sel", {31'd0, bus.sel_o}, 32'd0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(MTIMECMP_LO_OFS, 32'hFFFF_FFFF, "arst_cmp_lo");
    rd(MTIME_HI_OFS, 32'd0, "arst_mtime_hi");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
